// File: rtl/cpu_sequencer_if.sv
// cpu_sequencer_if: single shared 16-bit memory port handshake between
// the phase sequencer (master) and the memory subsystem (slave).
interface cpu_sequencer_if;
    logic       mem_req;
    logic       mem_we;
    logic       addr_sel;
    logic [1:0] byte_en;
    logic       mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        output addr_sel,
        output byte_en,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  addr_sel,
        input  byte_en,
        output mem_ack
    );
endinterface

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle FETCH/DECODE/EXEC/MEM/WB phase sequencer for the
// stack CPU core. Time-shares one memory port between instruction fetch and
// data access and produces the commit strobes for architectural updates.
// Optional interrupt entry state enabled by defining CPU_SEQ_IRQ_EN.
module cpu_sequencer #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rd_mem,
    input  logic               wr_mem,
    input  logic               byt,
    input  logic               addr0,
    input  logic               irq,
    cpu_sequencer_if.master    mem,
    output logic               load_insn,
    output logic               commit,
    output logic               wb_mem,
    output logic               irq_take,
    output logic               align_err,
    output logic               bus_err,
    output logic               halted
);

    localparam logic [2:0] S_RESET  = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_HALT   = 3'd7;
`ifdef CPU_SEQ_IRQ_EN
    localparam logic [2:0] S_INT    = 3'd6;
`endif

    // Counter value seen on the TIMEOUT-th consecutive wait cycle.
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

    logic [2:0]  state;
    logic [2:0]  next_state;
    logic [2:0]  retire_state;
    logic        rst_hold;
    logic [15:0] wait_cnt;
    logic        wr_q;
    logic [1:0]  be_q;
    logic        timeout_hit;

    logic        req_c;
    logic        we_c;
    logic        sel_c;
    logic [1:0]  be_c;

    assign timeout_hit = (wait_cnt == WAIT_LAST);

    assign mem.mem_req  = req_c;
    assign mem.mem_we   = we_c;
    assign mem.addr_sel = sel_c;
    assign mem.byte_en  = be_c;

`ifdef CPU_SEQ_IRQ_EN
    assign retire_state = irq ? S_INT : S_FETCH;
`else
    logic irq_unused;
    assign irq_unused   = irq;
    assign retire_state = S_FETCH;
`endif

    // Next-state and output decode; all outputs are combinational from state.
    always_comb begin
        next_state = state;
        req_c      = 1'b0;
        we_c       = 1'b0;
        sel_c      = 1'b0;
        be_c       = 2'b00;
        load_insn  = 1'b0;
        commit     = 1'b0;
        wb_mem     = 1'b0;
        irq_take   = 1'b0;
        align_err  = 1'b0;
        bus_err    = 1'b0;
        halted     = 1'b0;
        case (state)
            S_RESET: begin
                // One full cycle in RESET after release before fetching.
                next_state = rst_hold ? S_RESET : S_FETCH;
            end
            S_FETCH: begin
                req_c = 1'b1;
                be_c  = 2'b11;
                if (mem.mem_ack) begin
                    load_insn  = 1'b1;
                    next_state = S_DECODE;
                end else if (timeout_hit) begin
                    bus_err    = 1'b1;
                    next_state = S_HALT;
                end
            end
            S_DECODE: begin
                next_state = S_EXEC;
            end
            S_EXEC: begin
                if (!rd_mem && !wr_mem) begin
                    commit     = 1'b1;
                    next_state = retire_state;
                end else if (!byt && addr0) begin
                    align_err  = 1'b1;
                    next_state = retire_state;
                end else begin
                    next_state = S_MEM;
                end
            end
            S_MEM: begin
                req_c = 1'b1;
                sel_c = 1'b1;
                we_c  = wr_q;
                be_c  = be_q;
                if (mem.mem_ack) begin
                    if (wr_q) begin
                        commit     = 1'b1;
                        next_state = retire_state;
                    end else begin
                        next_state = S_WB;
                    end
                end else if (timeout_hit) begin
                    bus_err    = 1'b1;
                    next_state = S_HALT;
                end
            end
            S_WB: begin
                commit     = 1'b1;
                wb_mem     = 1'b1;
                next_state = retire_state;
            end
`ifdef CPU_SEQ_IRQ_EN
            S_INT: begin
                irq_take   = 1'b1;
                commit     = 1'b1;
                next_state = S_FETCH;
            end
`endif
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                next_state = S_RESET;
            end
        endcase
    end

    // State register with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_RESET;
            rst_hold <= 1'b1;
        end else begin
            state    <= next_state;
            rst_hold <= 1'b0;
        end
    end

    // Memory wait counter: cleared on every phase change, counts unacked cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (next_state != state) begin
            wait_cnt <= '0;
        end else if ((state == S_FETCH || state == S_MEM) && !mem.mem_ack) begin
            wait_cnt <= wait_cnt + 16'd1;
        end
    end

    // Capture decoder controls in EXEC so they may change during MEM/WB.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q <= 1'b0;
            be_q <= '0;
        end else if (state == S_EXEC) begin
            wr_q <= wr_mem;
            be_q <= byt ? (addr0 ? 2'b10 : 2'b01) : 2'b11;
        end
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: table-driven cycle checks of cpu_sequencer (TIMEOUT=4)
// plus hand-written timeout, halt, and asynchronous-reset sequences.
module tb_cpu_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rd_mem = 1'b0, wr_mem = 1'b0, byt = 1'b0, addr0 = 1'b0, irq = 1'b0;
    logic load_insn, commit, wb_mem, irq_take, align_err, bus_err, halted;

    int n_tests = 0;
    int n_fail  = 0;

    cpu_sequencer_if bus ();

    cpu_sequencer #(.TIMEOUT(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .rd_mem    (rd_mem),
        .wr_mem    (wr_mem),
        .byt       (byt),
        .addr0     (addr0),
        .irq       (irq),
        .mem       (bus.master),
        .load_insn (load_insn),
        .commit    (commit),
        .wb_mem    (wb_mem),
        .irq_take  (irq_take),
        .align_err (align_err),
        .bus_err   (bus_err),
        .halted    (halted)
    );

    always #5 clk = ~clk;

    // Inputs:  {rst}_{rd wr}_{byt a0}_{ack}_{irq}
    // Outputs: {req we sel}_{be}_{li cm wb it}_{ae berr halt}
    typedef struct {
        string      name;
        logic [6:0] in;
        logic [11:0] exp;
    } vec_t;

    localparam logic [11:0] Z    = 12'b000_00_0000_000;
    localparam logic [11:0] FW   = 12'b100_11_0000_000;
    localparam logic [11:0] FA   = 12'b100_11_1000_000;
    localparam logic [11:0] CM   = 12'b000_00_0100_000;
    localparam logic [11:0] MRB1 = 12'b101_10_0000_000;
    localparam logic [11:0] MRB0 = 12'b101_01_0000_000;
    localparam logic [11:0] MR11 = 12'b101_11_0000_000;
    localparam logic [11:0] MW01 = 12'b111_01_0100_000;
    localparam logic [11:0] WBC  = 12'b000_00_0110_000;
    localparam logic [11:0] AE   = 12'b000_00_0000_100;
    localparam logic [11:0] INTC = 12'b000_00_0101_000;
    localparam logic [11:0] FBE  = 12'b100_11_0000_010;
    localparam logic [11:0] HL   = 12'b000_00_0000_001;

    vec_t tbl[$];

    // Drive one cycle's inputs at the falling edge, compare outputs 1 ns later.
    task automatic step(input string nm, input logic [6:0] in, input logic [11:0] exp);
        logic [11:0] got;
        @(negedge clk);
        {rst, rd_mem, wr_mem, byt, addr0, bus.mem_ack, irq} = in;
        #1;
        got = {bus.mem_req, bus.mem_we, bus.addr_sel, bus.byte_en,
               load_insn, commit, wb_mem, irq_take, align_err, bus_err, halted};
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", nm, got, exp);
        end
    endtask

    initial begin
        bus.mem_ack = 1'b0;

        // Reset exit and a non-memory instruction.
        tbl.push_back('{"reset_state",    7'b1_00_00_0_0, Z});
        tbl.push_back('{"reset_release",  7'b0_00_00_0_0, Z});
        tbl.push_back('{"reset_hold",     7'b0_00_00_1_0, Z});
        tbl.push_back('{"fetch1_ack",     7'b0_00_00_1_0, FA});
        tbl.push_back('{"decode1_noack",  7'b0_00_00_1_0, Z});
        tbl.push_back('{"exec_nomem",     7'b0_00_00_1_0, CM});
        // Byte load at odd address with two wait states.
        tbl.push_back('{"fetch2_ack",     7'b0_00_00_1_0, FA});
        tbl.push_back('{"decode2",        7'b0_00_00_0_0, Z});
        tbl.push_back('{"exec_ldb_odd",   7'b0_10_11_0_0, Z});
        tbl.push_back('{"mem_ldb_wait1",  7'b0_00_00_0_1, MRB1});
        tbl.push_back('{"mem_ldb_wait2",  7'b0_01_10_0_0, MRB1});
        tbl.push_back('{"mem_ldb_ack",    7'b0_00_00_1_1, MRB1});
        tbl.push_back('{"wb_ldb",         7'b0_00_00_0_0, WBC});
        // Word store to odd address: alignment error, no data request.
        tbl.push_back('{"fetch3_ack",     7'b0_00_00_1_0, FA});
        tbl.push_back('{"decode3",        7'b0_00_00_0_0, Z});
        tbl.push_back('{"exec_stw_odd",   7'b0_01_01_0_0, AE});
        tbl.push_back('{"fetch_after_ae", 7'b0_00_00_1_0, FA});
        // Byte store at even address, zero wait.
        tbl.push_back('{"decode4",        7'b0_00_00_0_0, Z});
        tbl.push_back('{"exec_stb_even",  7'b0_01_10_0_0, Z});
        tbl.push_back('{"mem_stb_ack",    7'b0_01_10_1_0, MW01});
        // Word load at even address; decoder inputs change during MEM.
        tbl.push_back('{"fetch5_ack",     7'b0_00_00_1_0, FA});
        tbl.push_back('{"decode5",        7'b0_00_00_0_0, Z});
        tbl.push_back('{"exec_ldw_even",  7'b0_10_00_0_0, Z});
        tbl.push_back('{"mem_ldw_ack",    7'b0_01_11_1_0, MR11});
        tbl.push_back('{"wb_ldw",         7'b0_00_00_0_0, WBC});
        // Interrupt requested during the EXEC commit.
        tbl.push_back('{"fetch6_ack",     7'b0_00_00_1_1, FA});
        tbl.push_back('{"decode6_irq",    7'b0_00_00_0_1, Z});
        tbl.push_back('{"exec_irq",       7'b0_00_00_0_1, CM});
`ifdef CPU_SEQ_IRQ_EN
        tbl.push_back('{"int_entry",      7'b0_00_00_1_0, INTC});
`endif
        tbl.push_back('{"fetch_post_irq", 7'b0_00_00_1_0, FA});
        tbl.push_back('{"decode7",        7'b0_00_00_0_0, Z});
        tbl.push_back('{"exec7_nomem",    7'b0_00_00_0_0, CM});

        for (int unsigned i = 0; i < tbl.size(); i++)
            step(tbl[i].name, tbl[i].in, tbl[i].exp);

        // Ack lands on the timeout cycle in FETCH, then again in MEM.
        step("fetch_to_wait1", 7'b0_00_00_0_0, FW);
        step("fetch_to_wait2", 7'b0_00_00_0_0, FW);
        step("fetch_to_wait3", 7'b0_00_00_0_0, FW);
        step("fetch_to_ack",   7'b0_00_00_1_0, FA);
        step("decode_to",      7'b0_00_00_0_0, Z);
        step("exec_to_ldw",    7'b0_10_00_0_0, Z);
        step("mem_to_wait1",   7'b0_00_00_0_0, MR11);
        step("mem_to_wait2",   7'b0_00_00_0_0, MR11);
        step("mem_to_wait3",   7'b0_00_00_0_0, MR11);
        step("mem_to_ack",     7'b0_00_00_1_0, MR11);
        step("wb_to",          7'b0_00_00_0_0, WBC);

        // Fetch timeout: bus error on 4th wait cycle, then HALT until reset.
        step("fetch_tmo_w1",   7'b0_00_00_0_0, FW);
        step("fetch_tmo_w2",   7'b0_00_00_0_0, FW);
        step("fetch_tmo_w3",   7'b0_00_00_0_0, FW);
        step("fetch_bus_err",  7'b0_00_00_0_0, FBE);
        step("halt1",          7'b0_11_01_1_1, HL);
        step("halt2",          7'b0_00_00_1_1, HL);
        step("halt3",          7'b0_00_00_0_0, HL);
        step("halt_rst",       7'b1_00_00_0_0, Z);
        step("halt_rst_rel",   7'b0_00_00_0_0, Z);
        step("halt_rst_hold",  7'b0_00_00_0_0, Z);
        step("halt_refetch",   7'b0_00_00_1_0, FA);

        // Asynchronous reset in the middle of a data request.
        step("decode_ar",      7'b0_00_00_0_0, Z);
        step("exec_ar_ldb",    7'b0_10_10_0_0, Z);
        step("mem_ar_wait",    7'b0_00_00_0_0, MRB0);
        step("mem_ar_rst",     7'b1_00_00_0_0, Z);
        step("ar_release",     7'b0_00_00_0_0, Z);
        step("ar_hold",        7'b0_00_00_1_0, Z);
        step("ar_refetch",     7'b0_00_00_1_0, FA);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Multi-cycle phase sequencer for the stack CPU core. Steps each instruction through fetch, decode, execute, memory and write-back, time-sharing the single 16-bit memory port between instruction fetch (address from ip) and data access (address from the ALU). Consumes the decoder's memory-control outputs and generates the commit strobes that gate all architectural register updates.

## Interface
- `TIMEOUT`, 255: max cycles a memory request waits for `mem_ack` before a bus error; range 1..65535.
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `rd_mem`  in  1  decoder: instruction reads data memory.
- `wr_mem`  in  1  decoder: instruction writes data memory.
- `byt`  in  1  decoder: data access is one byte.
- `addr0`  in  1  bit 0 of the ALU-computed data address, valid in EXEC and MEM.
- `mem_ack`  in  1  memory completes the current request this cycle.
- `irq`  in  1  level interrupt request (see Configuration).
- `mem_req`  out  1  memory request active.
- `mem_we`  out  1  request is a write.
- `addr_sel`  out  1  0 = ip drives address, 1 = ALU result.
- `byte_en`  out  2  byte lanes; [0] = even address, [1] = odd address.
- `load_insn`  out  1  latch read data into the instruction register.
- `commit`  out  1  enable load_stk/load_fp/load_ip/cpush/cpop updates this cycle.
- `wb_mem`  out  1  stack top loads from memory read data (with `commit`).
- `irq_take`  out  1  interrupt entry cycle.
- `align_err`  out  1  one-cycle pulse: word access to an odd address.
- `bus_err`  out  1  one-cycle pulse: request timed out.
- `halted`  out  1  sequencer in HALT.

## Operation
- States: RESET, FETCH, DECODE, EXEC, MEM, WB, INT, HALT. Encoding is free.
- RESET: all outputs 0; next state FETCH.
- FETCH: `mem_req`=1, `mem_we`=0, `addr_sel`=0, `byte_en`=11. On `mem_ack`: `load_insn`=1 the same cycle, go DECODE.
- DECODE: one cycle, no outputs; go EXEC.
- EXEC, no memory (`rd_mem`=`wr_mem`=0): `commit`=1, go FETCH (or INT).
- EXEC, memory access, `byt`=0 and `addr0`=1: `align_err`=1, `commit`=0, no request issued, go FETCH (or INT). The instruction has no architectural effect.
- EXEC, otherwise: go MEM. `byte_en` is latched from EXEC inputs: `byt`=0 gives 11; `byt`=1 gives 01 when `addr0`=0, 10 when `addr0`=1.
- MEM: `mem_req`=1, `addr_sel`=1, `mem_we`=`wr_mem`, `byte_en` as latched. On `mem_ack`: for a write, `commit`=1 the same cycle and go FETCH/INT. For a read, go WB.
- WB: `commit`=1, `wb_mem`=1, go FETCH/INT.
- Timeout: a wait counter clears on entry to FETCH or MEM and increments each cycle without `mem_ack`. When it reaches `TIMEOUT`, `bus_err`=1 for that cycle, the request drops, and the state goes to HALT.
- HALT: `halted`=1, all other outputs 0. Only `rst` exits.
- `rd_mem`/`wr_mem`/`byt` are sampled in EXEC and held internally through MEM/WB. The decoder inputs may change after EXEC.

## Timing
- Non-memory instruction with zero-wait memory: 3 cycles (FETCH, DECODE, EXEC).
- Store: 4 cycles. Load: 5 cycles. Each memory wait cycle adds 1.
- `mem_req` is combinational from state. The request holds, with address and lanes stable, until the `mem_ack` cycle.
- `mem_ack` is ignored outside FETCH and MEM.
- `mem_ack` in the same cycle the counter reaches `TIMEOUT`: the ack wins and no `bus_err` is raised.
- Asserting `rst` mid-request drops `mem_req` immediately (asynchronous). After `rst` deasserts, the first edge enters RESET and the next edge enters FETCH.

## Configuration
- `CPU_SEQ_IRQ_EN` defined:
  - `irq` is sampled in every cycle that would transition to FETCH after a commit, align_err, or the store-ack cycle.
  - If `irq`=1, the next state is INT instead of FETCH.
  - INT: `irq_take`=1 and `commit`=1 for one cycle; the datapath performs cpush + load_ip via ind_jmp. Then go FETCH.
  - `irq` is never taken from RESET, HALT, or between phases of one instruction.
- `CPU_SEQ_IRQ_EN` undefined: the `irq` port is present but ignored, `irq_take` is constant 0, and the INT state is absent.

## Test plan
- Reset, then a non-memory instruction with `mem_ack`=1 always: FETCH→DECODE→EXEC; `load_insn` pulses at cycle 1 and `commit` at cycle 3; next `mem_req` at cycle 4.
- Load, `byt`=1, `addr0`=1, two wait states in MEM: `byte_en`=10, `addr_sel`=1, `mem_req` held 3 cycles; then WB with `commit`=`wb_mem`=1.
- Store word, `addr0`=1: `align_err` pulse in EXEC; no MEM-phase `mem_req`; `commit`=0; next cycle is FETCH.
- `TIMEOUT`=4, `mem_ack` held 0 in FETCH: `bus_err` pulses on the 4th wait cycle, then `halted`=1 persists; `rst` returns to RESET/FETCH.
- `mem_ack` arriving exactly on the timeout cycle: no `bus_err`; `load_insn`=1.
- With `CPU_SEQ_IRQ_EN`, `irq`=1 during the EXEC commit: the next cycle has `irq_take`=`commit`=1, then FETCH. Without the macro, the same stimulus goes straight to FETCH and `irq_take` stays 0.
